// File: rtl/dat_mem_init.sv
// dat_mem_init: W x D single-port data memory with power-up clear and constant-table loader
module dat_mem_init #(
    parameter int W         = 8,
    parameter int D         = 256,
    parameter int INIT_BASE = 60,
    parameter bit CLEAR_EN  = 1'b0,
    parameter bit REG_READ  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W-1:0]         dat_in,
    input  logic                 wr_en,
    input  logic [$clog2(D)-1:0] addr,
    output logic [W-1:0]         dat_out,
    output logic                 busy,
    output logic                 wr_drop
);
    localparam int AW = $clog2(D);
    // Constant/bit-mask table, entry 0 in the low byte.
    localparam logic [127:0] TABLE = {
        8'h3C, 8'h09, 8'h01, 8'hF8, 8'h40, 8'h08, 8'hFE, 8'h00,
        8'h10, 8'h80, 8'h1E, 8'hAA, 8'hCC, 8'hF0, 8'hE0, 8'h10
    };

    typedef enum logic [1:0] {CLEAR, LOAD, READY} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d, waddr;
    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  wdata;
    logic          we, wr_drop_q;

    if (INIT_BASE < 0 || INIT_BASE + 15 >= D || W < 8) begin : g_bad_params
        $error("dat_mem_init: constant table does not fit inside the array");
    end

    // Sequencer next state and the single shared write port (sequencer always wins over the core).
    always_comb begin
        state_d = (state_q == CLEAR && cnt_q == AW'(D - 1)) ? LOAD
                : (state_q == LOAD && cnt_q == AW'(15)) ? READY : state_q;
        cnt_d = (state_q == READY || state_d != state_q) ? '0 : cnt_q + AW'(1);
        we    = (state_q != READY) || wr_en;
        waddr = state_q == CLEAR ? cnt_q
              : state_q == LOAD ? AW'(INIT_BASE) + cnt_q : addr;
        wdata = state_q == CLEAR ? '0
              : state_q == LOAD ? W'(TABLE[{cnt_q[3:0], 3'b000} +: 8]) : dat_in;
    end

    // Sequencer state, walk counter and the dropped-write flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR_EN ? CLEAR : LOAD;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_en && state_q != READY;
        end
    end

    assign busy    = state_q != READY;
    assign wr_drop = wr_drop_q;

    // Array write; suppressed during reset so an aborted sequence leaves contents untouched.
    always_ff @(posedge clk) begin
        if (rst_n && we) mem_q[waddr] <= wdata;
    end

    if (REG_READ) begin : g_reg_read
        logic [W-1:0] rd_q;
        // Registered read captures the pre-write word on every edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_q <= '0;
            else rd_q <= mem_q[addr];
        end
        assign dat_out = rd_q;
    end else begin : g_comb_read
        assign dat_out = mem_q[addr];
    end
endmodule

// File: tb/tb_dat_mem_init.sv
// tb_dat_mem_init: three configurations of dat_mem_init checked against a time-indexed memory model
module tb_dat_mem_init;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults. Instance 1: CLEAR_EN=1, REG_READ=1. Instance 2: W=16, D=1024, INIT_BASE=1000.
    function automatic int dep(int i);            return i == 2 ? 1024 : 256; endfunction
    function automatic int base(int i);           return i == 2 ? 1000 : 60;  endfunction
    function automatic bit clr(int i);            return i == 1;              endfunction
    function automatic bit rr(int i);             return i == 1;              endfunction
    function automatic logic [15:0] wmask(int i); return i == 2 ? 16'hFFFF : 16'h00FF; endfunction
    function automatic int seq_len(int i);        return clr(i) ? dep(i) + 16 : 16; endfunction

    logic [7:0] tbl [16] = '{8'h10, 8'hE0, 8'hF0, 8'hCC, 8'hAA, 8'h1E, 8'h80, 8'h10,
                             8'h00, 8'hFE, 8'h08, 8'h40, 8'hF8, 8'h01, 8'h09, 8'h3C};

    logic        rst [3];
    logic        wr  [3];
    logic [9:0]  adr [3];
    logic [15:0] din [3];
    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_c;
    logic [2:0]  bsy, drp;

    dat_mem_init u_a (
        .clk(clk), .rst_n(rst[0]), .dat_in(din[0][7:0]), .wr_en(wr[0]), .addr(adr[0][7:0]),
        .dat_out(dout_a), .busy(bsy[0]), .wr_drop(drp[0])
    );
    dat_mem_init #(.CLEAR_EN(1'b1), .REG_READ(1'b1)) u_b (
        .clk(clk), .rst_n(rst[1]), .dat_in(din[1][7:0]), .wr_en(wr[1]), .addr(adr[1][7:0]),
        .dat_out(dout_b), .busy(bsy[1]), .wr_drop(drp[1])
    );
    dat_mem_init #(.W(16), .D(1024), .INIT_BASE(1000)) u_c (
        .clk(clk), .rst_n(rst[2]), .dat_in(din[2]), .wr_en(wr[2]), .addr(adr[2]),
        .dat_out(dout_c), .busy(bsy[2]), .wr_drop(drp[2])
    );

    function automatic logic [15:0] dout_of(int i);
        return i == 0 ? {8'h00, dout_a} : i == 1 ? {8'h00, dout_b} : dout_c;
    endfunction

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: k = rising edges since reset release; edge k < seq_len does the k-th init write.
    logic [15:0] mm  [3][1024];
    bit          kn  [3][1024];
    int          k   [3];
    bit          mdrop [3];
    logic [15:0] rq  [3];
    bit          rok [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int a, j;
            bit pb;
            a  = int'(adr[i]);
            pb = k[i] < seq_len(i);
            if (!rst[i]) begin
                k[i] <= 0; mdrop[i] <= 1'b0; rq[i] <= '0; rok[i] <= 1'b0;
            end else begin
                rq[i]    <= mm[i][a];
                rok[i]   <= !pb && kn[i][a];
                mdrop[i] <= wr[i] && pb;
                if (pb) begin
                    j = k[i] - (clr(i) ? dep(i) : 0);
                    if (j < 0) begin
                        mm[i][k[i]] <= '0; kn[i][k[i]] <= 1'b1;
                    end else begin
                        mm[i][base(i) + j] <= 16'(tbl[j]); kn[i][base(i) + j] <= 1'b1;
                    end
                    k[i] <= k[i] + 1;
                end else if (wr[i]) begin
                    mm[i][a] <= din[i] & wmask(i); kn[i][a] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit bz;
            bz = !rst[i] || k[i] < seq_len(i);
            chk($sformatf("busy%0d", i), 16'(bsy[i]), 16'(bz));
            chk($sformatf("wr_drop%0d", i), 16'(drp[i]), 16'(rst[i] && mdrop[i]));
            if (rr(i)) begin
                if (!rst[i]) chk($sformatf("rdq_reset%0d", i), dout_of(i), 16'h0000);
                else if (rok[i]) chk($sformatf("rdq%0d", i), dout_of(i), rq[i]);
            end else if (!bz && kn[i][adr[i]]) begin
                chk($sformatf("rd%0d@%0d", i, adr[i]), dout_of(i), mm[i][adr[i]]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(int i, int a, logic [15:0] e, string nm);
        adr[i] = 10'(a);
        wr[i]  = 1'b0;
        step();
        chk(nm, dout_of(i), e);
    endtask

    task automatic wr_word(int i, int a, logic [15:0] d);
        adr[i] = 10'(a);
        din[i] = d;
        wr[i]  = 1'b1;
        step();
        wr[i]  = 1'b0;
    endtask

    task automatic wait_ready(int i, int exp_n, string nm);
        int n;
        n = 0;
        while (bsy[i] && n < 1100) begin
            step();
            n++;
        end
        chk(nm, 16'(n), 16'(exp_n));
    endtask

    initial begin
        int n [3];
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; wr[i] = 1'b0; adr[i] = '0; din[i] = '0; n[i] = -1;
        end
        repeat (3) step();
        chk("rdq_during_reset", dout_of(1), 16'h0000);
        chk("busy_during_reset", 16'(bsy), 16'h0007);

        for (int i = 0; i < 3; i++) rst[i] = 1'b1;
        for (int s = 1; s <= 1100 && bsy != 3'b000; s++) begin
            if (s == 3) begin
                adr[0] = 10'd60; din[0] = 16'h00FF; wr[0] = 1'b1;
            end
            step();
            if (s == 3) begin
                wr[0] = 1'b0;
                chk("drop_pulse", 16'(drp[0]), 16'h0001);
            end
            if (s == 4) chk("drop_end", 16'(drp[0]), 16'h0000);
            for (int i = 0; i < 3; i++) if (!bsy[i] && n[i] < 0) n[i] = s;
        end
        chk("busy_edges_a", 16'(n[0]), 16'd16);
        chk("busy_edges_b", 16'(n[1]), 16'd272);
        chk("busy_edges_c", 16'(n[2]), 16'd16);

        rd_chk(0, 60, 16'h0010, "a60_after_drop");
        rd_chk(0, 64, 16'h00AA, "a64");
        rd_chk(0, 69, 16'h00FE, "a69");
        rd_chk(0, 75, 16'h003C, "a75");
        wr_word(0, 100, 16'h005A);
        rd_chk(0, 100, 16'h005A, "a100");

        rd_chk(2, 1004, 16'h00AA, "c1004");
        rd_chk(2, 1015, 16'h003C, "c1015");
        wr_word(2, 1023, 16'hBEEF);
        rd_chk(2, 1023, 16'hBEEF, "c1023");

        adr[1] = 10'd5; din[1] = 16'h00A5; wr[1] = 1'b1;
        step();
        wr[1] = 1'b0;
        chk("rr_old_data", dout_of(1), 16'h0000);
        step();
        chk("rr_new_data", dout_of(1), 16'h00A5);

        wr_word(1, 0, 16'h0077);
        wr_word(1, 200, 16'h0033);
        rd_chk(1, 0, 16'h0077, "b0_preload");
        rst[1] = 1'b0;
        step();
        step();
        rst[1] = 1'b1;
        wait_ready(1, 272, "busy_edges_b_rerun");
        rd_chk(1, 0, 16'h0000, "b0_cleared");
        rd_chk(1, 200, 16'h0000, "b200_cleared");
        rd_chk(1, 67, 16'h0010, "b67");
        rd_chk(1, 68, 16'h0000, "b68");

        rst[0] = 1'b0;
        step();
        rst[0] = 1'b1;
        repeat (7) step();
        rst[0] = 1'b0;
        step();
        rst[0] = 1'b1;
        wait_ready(0, 16, "busy_edges_a_restart");
        for (int j = 0; j < 16; j++) rd_chk(0, 60 + j, 16'(tbl[j]), $sformatf("a_tbl%0d", j));

        repeat (600) begin
            for (int i = 0; i < 3; i++) begin
                if (!rst[i]) rst[i] = 1'b1;
                else if ($urandom_range(249) == 0) rst[i] = 1'b0;
                wr[i]  = $urandom_range(2) == 0;
                adr[i] = i == 2 ? 10'($urandom_range(1023)) : 10'($urandom_range(255));
                din[i] = 16'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
